// File: rtl/sfx_audio_out.sv
// Pong sound-effect back end: beat index -> square-wave note -> 16-bit left-justified I2S, same sample on both channels.
// A tone change reaches sdin at the next lrck frame (<=512 clk); no backpressure. Optional decay envelope under SFX_FADE_EN.
module sfx_audio_out #(
    parameter int          CLK_HZ       = 100000000,
    parameter logic [15:0] AMP          = 16'h2000,
    parameter int          FADE_SAMPLES = 2048
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ibeat,
    input  logic       mute,
    output logic       audio_mclk,
    output logic       audio_lrck,
    output logic       audio_sck,
    output logic       audio_sdin,
    output logic       note_active
);

    localparam logic [31:0] HP_523  = 32'(CLK_HZ / (2 * 523));
    localparam logic [31:0] HP_659  = 32'(CLK_HZ / (2 * 659));
    localparam logic [31:0] HP_784  = 32'(CLK_HZ / (2 * 784));
    localparam logic [31:0] HP_1047 = 32'(CLK_HZ / (2 * 1047));
    localparam logic [31:0] HP_1568 = 32'(CLK_HZ / (2 * 1568));

    logic [8:0]  div_q, div_d;
    logic [7:0]  ibeat_q, ibeat_d;
    logic [31:0] tone_cnt_q, tone_cnt_d;
    logic        level_q, level_d;
    logic [15:0] sample_reg_q, sample_reg_d;
    logic        sdin_q, sdin_d;
    logic        note_active_q, note_active_d;

    logic [31:0] half_period;
    logic        note_on;
    logic        note_chg;
    logic        latch_en;
    logic [15:0] amp;
    logic [15:0] sample_val;
    logic [3:0]  bit_idx;

    // A zero half period doubles as the "silent" marker.
    always_comb begin : note_table
        half_period = 32'd0;
        case (ibeat_q)
            8'd6:    half_period = HP_1047;
            8'd7:    half_period = HP_1568;
            8'd8:    half_period = HP_523;
            8'd9:    half_period = HP_659;
            8'd10:   half_period = HP_784;
            8'd11:   half_period = HP_1047;
            8'd12:   half_period = HP_784;
            8'd13:   half_period = HP_1047;
            default: half_period = 32'd0;
        endcase
        note_on = (half_period != 32'd0);
    end

    assign note_chg = (ibeat != ibeat_q);
    assign latch_en = (div_q == 9'd511);

    always_comb begin : tone_gen
        ibeat_d    = ibeat;
        tone_cnt_d = tone_cnt_q;
        level_d    = level_q;
        if (note_chg || !note_on) begin
            tone_cnt_d = 32'd0;
            level_d    = 1'b0;
        end else if (tone_cnt_q == half_period - 32'd1) begin
            tone_cnt_d = 32'd0;
            level_d    = ~level_q;
        end else begin
            tone_cnt_d = tone_cnt_q + 32'd1;
        end
    end

`ifdef SFX_FADE_EN
    localparam logic [15:0] AMP_FLOOR = AMP >> 4;
    localparam logic [31:0] FADE_LAST = 32'(FADE_SAMPLES - 1);

    logic [15:0] amp_cur_q, amp_cur_d;
    logic [31:0] fade_cnt_q, fade_cnt_d;
    logic [15:0] amp_half;

    always_comb begin : envelope
        amp_cur_d  = amp_cur_q;
        fade_cnt_d = fade_cnt_q;
        amp_half   = amp_cur_q >> 1;
        if (note_chg) begin
            amp_cur_d  = AMP;
            fade_cnt_d = 32'd0;
        end else if (latch_en) begin
            if (fade_cnt_q == FADE_LAST) begin
                fade_cnt_d = 32'd0;
                amp_cur_d  = (amp_half < AMP_FLOOR) ? AMP_FLOOR : amp_half;
            end else begin
                fade_cnt_d = fade_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            amp_cur_q  <= AMP;
            fade_cnt_q <= 32'd0;
        end else begin
            amp_cur_q  <= amp_cur_d;
            fade_cnt_q <= fade_cnt_d;
        end
    end

    assign amp = amp_cur_q;
`else
    localparam int fade_unused = FADE_SAMPLES;

    assign amp = AMP;
`endif

    // The sdin flop loads the bit for the next sck period, so the index looks one nibble
    // ahead; at the frame wrap it must read the sample being latched on the same edge.
    always_comb begin : sample_path
        sample_val = level_q ? amp : (16'd0 - amp);
        if (mute || !note_on) begin
            sample_val = 16'd0;
        end
        sample_reg_d  = latch_en ? sample_val : sample_reg_q;
        note_active_d = note_on;
        div_d         = div_q + 9'd1;
        bit_idx       = 4'd14 - div_q[7:4];
        sdin_d        = (div_q[3:0] == 4'hF) ? sample_reg_d[bit_idx] : sdin_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q         <= 9'd0;
            ibeat_q       <= 8'd0;
            tone_cnt_q    <= 32'd0;
            level_q       <= 1'b0;
            sample_reg_q  <= 16'd0;
            sdin_q        <= 1'b0;
            note_active_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            ibeat_q       <= ibeat_d;
            tone_cnt_q    <= tone_cnt_d;
            level_q       <= level_d;
            sample_reg_q  <= sample_reg_d;
            sdin_q        <= sdin_d;
            note_active_q <= note_active_d;
        end
    end

    assign audio_mclk  = div_q[1];
    assign audio_sck   = div_q[3];
    assign audio_lrck  = div_q[8];
    assign audio_sdin  = sdin_q;
    assign note_active = note_active_q;

endmodule

// File: doc/sfx_audio_out.md
Name: sfx_audio_out

Overview:
Sound-effect back end for the Pong audio path. Consumes the 8-bit beat index produced by the player/sound controller (0 = silent, 6–7 = collision tones, 8–13 = win jingle) and maps it to a note frequency. Generates a square-wave PCM sample stream and serializes it to the on-board I2S DAC pins (mclk/lrck/sck/sdin), identical on left and right channels.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz; used for the note half-period constants
AMP, 16'h2000, square-wave peak magnitude (signed 16-bit, positive value)
FADE_SAMPLES, 2048, lrck periods per fade step (used only with SFX_FADE_EN)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
ibeat  input  8  beat index from the sound controller
mute  input  1  1 = force sample to 0; tone counters keep running
audio_mclk  output  1  DAC master clock = clk/4
audio_lrck  output  1  word select = clk/512; 0 = left, 1 = right
audio_sck  output  1  bit clock = clk/16
audio_sdin  output  1  serial data, MSB first
note_active  output  1  1 while the current ibeat maps to a non-silent note

Behaviour:
- One clock, clk. Reset sampled on the clk rising edge; active when low. Polarity and synchronicity are fixed.
- Reset values: div=0, tone_cnt=0, level=0, sample_reg=0, shift data=0. All audio outputs read 0; note_active=0.
- Master divider: div[8:0] is free-running, +1 per clk, wraps 511→0.
  - audio_mclk = div[1]; audio_sck = div[3]; audio_lrck = div[8].
- Note table, combinational, half_period = CLK_HZ/(2*f) using integer division:
  - 6→1047 Hz; 7→1568 Hz.
  - 8→523; 9→659; 10→784; 11→1047; 12→784; 13→1047.
  - Any other value, including 0 → silence.
- Note change: ibeat is registered as ibeat_q. When ibeat != ibeat_q, the next cycle gets tone_cnt=0 and level=0. Retriggering the same value does not restart the phase.
- Tone generator, for non-silent notes:
  - tone_cnt increments each clk.
  - When tone_cnt == half_period-1: tone_cnt←0 and level toggles.
  - Silence holds tone_cnt=0 and level=0.
- Sample value: +AMP if level=1, −AMP if level=0. The value is 0 if the note is silent or mute=1.
- note_active is registered and equals (ibeat_q maps to a non-silent note). It is 1 cycle behind ibeat_q.
- Sample latch: sample_reg captures the sample value when div==511. Both channels of the following lrck period transmit sample_reg, so sample latency is ≤512 clk.
- Serializer, per channel half:
  - bit index = 15 − div[7:4]; audio_sdin = sample_reg[bit index].
  - audio_sdin is registered and updated when div[3:0]==4'b1111, so it changes on the sck falling edge.
  - Left-justified, 16 bits per channel, 2×16 sck per lrck period.
- Boundaries:
  - ibeat change mid-sample: takes effect on the next latch only.
  - mute toggling mid-word: does not corrupt the current word.
  - Reset asserted mid-word: all outputs are 0 on the next edge.
  - div wrap and note change in the same cycle: both apply, and the latch uses the pre-change level.

Optional Feature:
Macro SFX_FADE_EN.
- Defined: per-note decay envelope.
  - amp_cur←AMP on every note change.
  - Every FADE_SAMPLES lrck periods, amp_cur←amp_cur>>1, with a floor of AMP>>4.
  - The sample uses ±amp_cur.
- Not defined: amplitude is constant ±AMP, and no envelope registers exist.

Test Plan:
- Reset held low 10 cycles, then ibeat=0 → all audio outputs 0 during reset; afterwards sdin stays 0 and note_active=0; mclk period 4 clk, sck 16, lrck 512.
- ibeat=8 held → level toggles every 95602 clk (100e6/1046); note_active=1 one cycle after ibeat_q updates.
- ibeat=6 then ibeat=11 → both use half_period 47755, but the phase restarts (tone_cnt=0, level=0) on the 6→11 change.
- level=1 latched at div==511 with AMP=16'h2000 → next left word on sdin reads 0010_0000_0000_0000 MSB first; the right word is identical.
- level=0 latched → sdin word 16'hE000; with mute=1 → word 16'h0000 while tone_cnt keeps counting.
- SFX_FADE_EN defined, FADE_SAMPLES=4, ibeat=9 → peak steps 0x2000, 0x1000, 0x0800, 0x0400, 0x0200, then holds 0x0200; a new ibeat restores 0x2000.
